vga_scanout: RTL

Frame-buffer reader and VGA timing generator for the 160x120, 3-bit-colour video path. The drawing logic writes pixels into a 19,200-entry video RAM by (x, y) address. This block reads that RAM back in raster order, upscales each stored pixel to a 4x4 block, and drives the board's VGA DAC with 640x480 @ 60 Hz timing. It also reports vertical blanking so the drawing logic can pace frame updates.

---
 rtl/vga_scanout.sv | 125 ++++++++++++
 1 files changed

// File: rtl/vga_scanout.sv
// 160x120 frame-buffer scanout: reads video RAM in raster order, upscales each
// pixel to a 4x4 block and drives a 640x480 @ 60 Hz VGA DAC from the 50 MHz clock.
module vga_scanout #(
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33
) (
    input  logic        CLOCK_50,
    input  logic        reset_n,
    output logic [14:0] mem_addr,
    input  logic [2:0]  mem_q,
    output logic        VGA_CLK,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK_N,
    output logic        VGA_SYNC_N,
    output logic [9:0]  VGA_R,
    output logic [9:0]  VGA_G,
    output logic [9:0]  VGA_B,
    output logic        in_vblank,
    output logic        frame_start
);

    localparam logic [9:0] H_VIS     = 10'd640;
    localparam logic [9:0] V_VIS     = 10'd480;
    localparam logic [9:0] H_LAST    = 10'(640 + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST    = 10'(480 + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] HS_FIRST  = 10'(640 + H_FP);
    localparam logic [9:0] HS_LAST   = 10'(640 + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST  = 10'(480 + V_FP);
    localparam logic [9:0] VS_LAST   = 10'(480 + V_FP + V_SYNC - 1);

    // y*160 + x as shift-and-add; 119*160 + 159 = 19199 fits in 15 bits
    function automatic logic [14:0] pix_addr(input logic [6:0] y, input logic [7:0] x);
        logic [14:0] yw;
        yw = {8'd0, y};
        return (yw << 7) + (yw << 5) + {7'd0, x};
    endfunction

    function automatic logic [9:0] expand(input logic bit_i, input logic vis_i);
        return (bit_i && vis_i) ? 10'h3FF : 10'h000;
    endfunction

    logic        phase_q;
    logic [9:0]  h_cnt_q, h_cnt_d;
    logic [9:0]  v_cnt_q, v_cnt_d;
    logic        pix_en;
    logic        visible, hs_win, vs_win;
    logic [14:0] mem_addr_q;
    logic        vis_p1_q, hs_p1_q, vs_p1_q;
    logic        hs_n_p2_q, vs_n_p2_q, blank_n_p2_q;
    logic [9:0]  r_p2_q, g_p2_q, b_p2_q;

    assign pix_en  = phase_q;
    assign visible = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
    assign hs_win  = (h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST);
    assign vs_win  = (v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST);

    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (pix_en) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
            end else begin
                h_cnt_d = h_cnt_q + 10'd1;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            phase_q      <= 1'b0;
            h_cnt_q      <= '0;
            v_cnt_q      <= '0;
            mem_addr_q   <= '0;
            vis_p1_q     <= 1'b0;
            hs_p1_q      <= 1'b0;
            vs_p1_q      <= 1'b0;
            hs_n_p2_q    <= 1'b1;
            vs_n_p2_q    <= 1'b1;
            blank_n_p2_q <= 1'b0;
            r_p2_q       <= '0;
            g_p2_q       <= '0;
            b_p2_q       <= '0;
        end else begin
            phase_q <= ~phase_q;
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            if (pix_en) begin
                // stage 1: issue RAM read, delay timing flags to match
                if (visible) begin
                    mem_addr_q <= pix_addr(v_cnt_q[8:2], h_cnt_q[9:2]);
                end
                vis_p1_q <= visible;
                hs_p1_q  <= hs_win;
                vs_p1_q  <= vs_win;
                // stage 2: RAM data has had two clock edges to settle
                hs_n_p2_q    <= ~hs_p1_q;
                vs_n_p2_q    <= ~vs_p1_q;
                blank_n_p2_q <= vis_p1_q;
                r_p2_q       <= expand(mem_q[2], vis_p1_q);
                g_p2_q       <= expand(mem_q[1], vis_p1_q);
                b_p2_q       <= expand(mem_q[0], vis_p1_q);
            end
        end
    end

    assign mem_addr    = mem_addr_q;
    assign VGA_CLK     = phase_q;
    assign VGA_HS      = hs_n_p2_q;
    assign VGA_VS      = vs_n_p2_q;
    assign VGA_BLANK_N = blank_n_p2_q;
    assign VGA_SYNC_N  = 1'b1;
    assign VGA_R       = r_p2_q;
    assign VGA_G       = g_p2_q;
    assign VGA_B       = b_p2_q;
    assign in_vblank   = (v_cnt_q >= V_VIS);
    assign frame_start = pix_en && (h_cnt_q == 10'd0) && (v_cnt_q == V_VIS);

endmodule
